// File: rtl/spi_master_multi_cs.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_multi_cs
// Brief    : SPI master with NUM_CS one-hot chip selects and multi-word bursts
//            under one CS assertion. Define SPI_LSB_FIRST_EN to add i_LSB_First.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_multi_cs #(
    parameter int SPI_MODE          = 0,
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_CS            = 4,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 1,
    parameter int MAX_WORDS_PER_CS  = 2,
    localparam int CW               = $clog2(MAX_WORDS_PER_CS + 1),
    // One bit wider than a bare select index so out-of-range requests are expressible.
    localparam int SEL_W            = $clog2(NUM_CS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      i_CS_Sel,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  i_LSB_First,
`endif
    input  logic [CW-1:0]         i_TX_Count,
    input  logic [WORD_WIDTH-1:0] i_TX_Word,
    input  logic                  i_TX_En,
    output logic                  o_TX_Ready,
    output logic                  o_Sel_Err,
    output logic [WORD_WIDTH-1:0] o_RX_Word,
    output logic                  o_RX_En,
    output logic [CW-1:0]         o_RX_Count,
    output logic                  o_SPCK,
    output logic                  o_MOSI,
    input  logic                  i_MISO,
    output logic [NUM_CS-1:0]     o_CS_n
);

    localparam logic CPOL = 1'((SPI_MODE >> 1) & 1);
    localparam logic CPHA = 1'(SPI_MODE & 1);
    localparam int   HW   = $clog2(CLKS_PER_HALF_BIT);
    localparam int   EW   = $clog2(2 * WORD_WIDTH + 1);
    localparam int   GW   = $clog2(CS_INACTIVE_CLKS + 1);

    localparam logic [HW-1:0] HALF_MAX  = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WORD_WIDTH - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(CS_INACTIVE_CLKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_XFER      = 2'd1,
        ST_WAIT_NEXT = 2'd2,
        ST_CS_GAP    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  sel_err_q, sel_err_d;
    logic [WORD_WIDTH-1:0] rx_word_q, rx_word_d;
    logic                  rx_en_q, rx_en_d;
    logic [CW-1:0]         rx_count_q, rx_count_d;
    logic                  spck_q, spck_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [HW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;

    logic w_sel_ok;
    logic w_load;
    logic w_sample;
    logic w_last;
    logic w_lsb_load;
    logic lsb_q;

    assign w_sel_ok = (i_CS_Sel < SEL_W'(NUM_CS));
    // Even edge count means the next SPCK edge is a leading one.
    assign w_sample = (~edge_cnt_q[0]) ^ CPHA;
    assign w_last   = (edge_cnt_q == EDGE_LAST);

`ifdef SPI_LSB_FIRST_EN
    logic lsb_d;
    assign w_lsb_load = (state_q == ST_IDLE) ? i_LSB_First : lsb_q;
    assign lsb_d      = (state_q == ST_IDLE && i_TX_En && ready_q && w_sel_ok)
                        ? i_LSB_First : lsb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsb_q <= 1'b0;
        end else begin
            lsb_q <= lsb_d;
        end
    end
`else
    assign lsb_q      = 1'b0;
    assign w_lsb_load = 1'b0;
`endif

    function automatic logic first_bit(input logic [WORD_WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[WORD_WIDTH-1];
    endfunction

    function automatic logic [WORD_WIDTH-1:0] shift_out(input logic [WORD_WIDTH-1:0] v,
                                                        input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [WORD_WIDTH-1:0] shift_in(input logic [WORD_WIDTH-1:0] v,
                                                       input logic lsb, input logic b);
        return lsb ? {b, v[WORD_WIDTH-1:1]} : {v[WORD_WIDTH-2:0], b};
    endfunction

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        sel_err_d  = 1'b0;
        rx_word_d  = rx_word_q;
        rx_en_d    = 1'b0;
        rx_count_d = rx_count_q;
        spck_d     = spck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        cnt_d      = cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        clk_cnt_d  = clk_cnt_q;
        edge_cnt_d = edge_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        w_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (i_TX_En && ready_q) begin
                    if (w_sel_ok) begin
                        w_load     = 1'b1;
                        cnt_d      = (i_TX_Count == '0) ? CW'(1) : i_TX_Count;
                        rx_count_d = '0;
                        for (int i = 0; i < NUM_CS; i++) begin
                            cs_n_d[i] = (i_CS_Sel != SEL_W'(i));
                        end
                        state_d = ST_XFER;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end

            ST_WAIT_NEXT: begin
                if (i_TX_En && ready_q) begin
                    w_load  = 1'b1;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (clk_cnt_q == HALF_MAX) begin
                    clk_cnt_d  = '0;
                    spck_d     = ~spck_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (w_sample) begin
                        rx_shift_d = shift_in(rx_shift_q, lsb_q, i_MISO);
                    end else if (!w_last) begin
                        mosi_d     = first_bit(tx_shift_q, lsb_q);
                        tx_shift_d = shift_out(tx_shift_q, lsb_q);
                    end
                    if (w_last) begin
                        rx_en_d    = 1'b1;
                        rx_word_d  = rx_shift_d;
                        rx_count_d = rx_count_q + 1'b1;
                        if (rx_count_d < cnt_q) begin
                            state_d = ST_WAIT_NEXT;
                            ready_d = 1'b1;
                        end else begin
                            state_d   = ST_CS_GAP;
                            cs_n_d    = '1;
                            gap_cnt_d = '0;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            ST_CS_GAP: begin
                if (gap_cnt_q == GAP_MAX) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // With CPHA=1 the first bit goes out on the leading edge, so MOSI is left alone here.
        if (w_load) begin
            ready_d    = 1'b0;
            clk_cnt_d  = '0;
            edge_cnt_d = '0;
            rx_shift_d = '0;
            tx_shift_d = CPHA ? i_TX_Word : shift_out(i_TX_Word, w_lsb_load);
            mosi_d     = CPHA ? mosi_q : first_bit(i_TX_Word, w_lsb_load);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            sel_err_q  <= 1'b0;
            rx_word_q  <= '0;
            rx_en_q    <= 1'b0;
            rx_count_q <= '0;
            spck_q     <= CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            cnt_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            clk_cnt_q  <= '0;
            edge_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            sel_err_q  <= sel_err_d;
            rx_word_q  <= rx_word_d;
            rx_en_q    <= rx_en_d;
            rx_count_q <= rx_count_d;
            spck_q     <= spck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            cnt_q      <= cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            clk_cnt_q  <= clk_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign o_TX_Ready = ready_q;
    assign o_Sel_Err  = sel_err_q;
    assign o_RX_Word  = rx_word_q;
    assign o_RX_En    = rx_en_q;
    assign o_RX_Count = rx_count_q;
    assign o_SPCK     = spck_q;
    assign o_MOSI     = mosi_q;
    assign o_CS_n     = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi_cs.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_multi_cs
// Brief    : Directed bench for spi_master_multi_cs, one instance per SPI mode,
//            MISO looped to MOSI. Exercises i_LSB_First when SPI_LSB_FIRST_EN set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_multi_cs;

    localparam int WW  = 16;
    localparam int NCS = 4;
    localparam int CW  = 2;
    localparam int SW  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [SW-1:0] cs_sel;
    logic [CW-1:0] tx_count;
    logic [WW-1:0] tx_word;
    logic          tx_en;
`ifdef SPI_LSB_FIRST_EN
    logic          lsb_first;
`endif

    logic [3:0]     ready, sel_err, rx_en, spck, mosi;
    logic [WW-1:0]  rx_word  [4];
    logic [CW-1:0]  rx_count [4];
    logic [NCS-1:0] cs_n     [4];

    generate
        for (genvar m = 0; m < 4; m++) begin : g_mode
            spi_master_multi_cs #(
                .SPI_MODE          (m),
                .WORD_WIDTH        (WW),
                .NUM_CS            (NCS),
                .CLKS_PER_HALF_BIT (2),
                .CS_INACTIVE_CLKS  (1),
                .MAX_WORDS_PER_CS  (3)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .i_CS_Sel    (cs_sel),
`ifdef SPI_LSB_FIRST_EN
                .i_LSB_First (lsb_first),
`endif
                .i_TX_Count  (tx_count),
                .i_TX_Word   (tx_word),
                .i_TX_En     (tx_en),
                .o_TX_Ready  (ready[m]),
                .o_Sel_Err   (sel_err[m]),
                .o_RX_Word   (rx_word[m]),
                .o_RX_En     (rx_en[m]),
                .o_RX_Count  (rx_count[m]),
                .o_SPCK      (spck[m]),
                .o_MOSI      (mosi[m]),
                .i_MISO      (mosi[m]),
                .o_CS_n      (cs_n[m])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Mid-cycle observer of pulses and SPCK activity
    int            rx_n [4] = '{0, 0, 0, 0};
    logic [WW-1:0] rx_got  [4];
    logic [CW-1:0] rxc_got [4];
    int            rise_n    = 0;
    int            tog_n     = 0;
    int            sel_err_n = 0;
    int            cs_glitch = 0;
    logic          spck_prev = 1'b0;
    logic          cs_watch  = 1'b0;

    always @(posedge clk) begin
        #2;
        for (int m = 0; m < 4; m++) begin
            if (rx_en[m] === 1'b1) begin
                rx_n[m]++;
                rx_got[m]  = rx_word[m];
                rxc_got[m] = rx_count[m];
            end
        end
        if (spck[0] !== spck_prev) begin
            tog_n++;
            if (spck[0] === 1'b1) rise_n++;
        end
        spck_prev = spck[0];
        if (sel_err[0] === 1'b1) sel_err_n++;
        if (cs_watch && rx_en[0] !== 1'b1 && cs_n[0] !== 4'b1011) cs_glitch++;
    end

    task automatic send(input logic [SW-1:0] s, input logic [CW-1:0] c, input logic [WW-1:0] w);
        @(negedge clk);
        cs_sel   = s;
        tx_count = c;
        tx_word  = w;
        tx_en    = 1'b1;
        @(negedge clk);
        tx_en    = 1'b0;
    endtask

    task automatic wait_rx(input int target, input string tag);
        int k = 0;
        while (rx_n[0] < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(rx_n[0] >= target), 32'd1);
    endtask

    int base;
    int k;

    initial begin
        rst      = 1'b1;
        tx_en    = 1'b0;
        cs_sel   = '0;
        tx_count = '0;
        tx_word  = '0;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (10) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n[0]), 32'hF);
        chk("rst_spck", 32'(spck), 32'hC);
        chk("rst_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(ready), 32'hF);

        // Single word on CS1, all four modes in parallel
        base = rise_n;
        send(3'd1, 2'd1, 16'hA5C3);
        chk("single_cs_n", 32'(cs_n[0]), 32'b1101);
        chk("single_first_mosi", 32'(mosi[0]), 32'd1);
        chk("single_busy", 32'(ready[0]), 32'd0);
        wait_rx(1, "single_rx_timeout");
        chk("single_rx_word", 32'(rx_got[0]), 32'hA5C3);
        chk("single_rx_count", 32'(rxc_got[0]), 32'd1);
        chk("single_spck_pulses", 32'(rise_n - base), 32'd16);
        chk("single_spck_idle", 32'(spck), 32'hC);
        for (int m = 1; m < 4; m++) begin
            chk($sformatf("mode%0d_rx_word", m), 32'(rx_got[m]), 32'hA5C3);
        end
        chk("single_cs_release", 32'(cs_n[0]), 32'hF);

        // Three-word burst on CS2; later requests carry stray sel/count
        send(3'd2, 2'd3, 16'h0001);
        chk("burst_cs_n", 32'(cs_n[0]), 32'b1011);
        cs_watch = 1'b1;
        wait_rx(2, "burst_w1_timeout");
        chk("burst_w1_word", 32'(rx_got[0]), 32'h0001);
        chk("burst_w1_count", 32'(rxc_got[0]), 32'd1);
        chk("burst_wait_ready", 32'(ready[0]), 32'd1);
        send(3'd0, 2'd1, 16'h8000);
        chk("burst_w2_cs_n", 32'(cs_n[0]), 32'b1011);
        wait_rx(3, "burst_w2_timeout");
        chk("burst_w2_word", 32'(rx_got[0]), 32'h8000);
        chk("burst_w2_count", 32'(rxc_got[0]), 32'd2);
        send(3'd3, 2'd1, 16'hFFFF);
        wait_rx(4, "burst_w3_timeout");
        cs_watch = 1'b0;
        chk("burst_w3_word", 32'(rx_got[0]), 32'hFFFF);
        chk("burst_w3_count", 32'(rxc_got[0]), 32'd3);
        chk("burst_end_cs_n", 32'(cs_n[0]), 32'hF);
        chk("burst_gap_ready", 32'(ready[0]), 32'd0);
        chk("burst_cs_held", 32'(cs_glitch), 32'd0);
        @(negedge clk);
        chk("gap_done_ready", 32'(ready[0]), 32'd1);

        // Out-of-range select
        send(3'd4, 2'd1, 16'h1234);
        base = tog_n;
        chk("selerr_pulse", 32'(sel_err[0]), 32'd1);
        chk("selerr_cs_n", 32'(cs_n[0]), 32'hF);
        chk("selerr_ready", 32'(ready[0]), 32'd1);
        @(negedge clk);
        chk("selerr_cleared", 32'(sel_err[0]), 32'd0);
        repeat (6) @(negedge clk);
        chk("selerr_no_spck", 32'(tog_n - base), 32'd0);
        chk("selerr_single", 32'(sel_err_n), 32'd1);
        chk("rx_count_hold", 32'(rx_count[0]), 32'd3);

        // Reset in the middle of a word
        send(3'd0, 2'd1, 16'hFFFF);
        chk("abort_rx_count_clr", 32'(rx_count[0]), 32'd0);
        chk("abort_cs_n", 32'(cs_n[0]), 32'b1110);
        base = tog_n;
        k = 0;
        while (tog_n < base + 5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("abort_edges_seen", 32'(tog_n >= base + 5), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_cs_n_rst", 32'(cs_n[0]), 32'hF);
        chk("abort_spck_rst", 32'(spck), 32'hC);
        base = rx_n[0];
        repeat (20) @(negedge clk);
        chk("abort_no_rx", 32'(rx_n[0]), 32'(base));
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
        send(3'd3, 2'd1, 16'h0001);
        lsb_first = 1'b0;
        chk("lsb_first_mosi", 32'(mosi[0]), 32'd1);
        wait_rx(base + 1, "lsb_timeout");
        chk("lsb_rx_word", 32'(rx_got[0]), 32'h0001);
        for (int m = 1; m < 4; m++) begin
            chk($sformatf("lsb_mode%0d_rx_word", m), 32'(rx_got[m]), 32'h0001);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
